// File: rtl/sram_responder.sv
// Clocked model of a 16-bit asynchronous SRAM sitting on the SRAM_* pin bus.
// Define SRAM_PROTOCOL_CHECK_EN to build the sticky protocol-violation checker behind proto_err.

module sram_byte_lane #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata,
  input  logic [AW-1:0] dbg_addr,
  output logic [7:0]    dbg_data
);
  logic [7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata    = mem[raddr];
  assign dbg_data = mem[dbg_addr];
endmodule

module sram_responder #(
  parameter int MEM_AW   = 10,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [15:0]       SRAM_DQ,
  input  logic [17:0]       SRAM_ADDR,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_OE_N,
  input  logic [MEM_AW-1:0] dbg_addr,
  output logic [15:0]       dbg_data,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic              proto_err
);
  localparam int       NUM_LANES = 2;
  localparam bit [2:0] LAT_LOAD  = 3'(READ_LAT - 1);

  typedef enum logic [1:0] {IDLE, READ_WAIT, READ_DRIVE, WRITE} state_t;

  state_t        state, state_nx;
  logic [2:0]    lat_cnt, lat_nx;
  logic [17:0]   addr_q, addr_nx;
  logic [15:0]   wdata_q, wdata_nx;
  logic [1:0]    ben_n_q, ben_n_nx;
  logic [15:0]   dq_out, rd_masked;
  logic          dq_oe;
  logic          sel, wr_req, rd_req, addr_chg;
  logic          commit, rd_enter, wr_latch;

  assign sel      = ~SRAM_CE_N;
  assign wr_req   = sel & ~SRAM_WE_N;
  assign rd_req   = sel & SRAM_WE_N & ~SRAM_OE_N;
  assign addr_chg = (SRAM_ADDR != addr_q);

  // WE_N low gates the driver immediately so we never fight the controller's write data.
  assign SRAM_DQ = (dq_oe && SRAM_WE_N) ? dq_out : 16'bz;

  always_comb begin
    state_nx = state;
    lat_nx   = lat_cnt;
    addr_nx  = addr_q;
    wdata_nx = wdata_q;
    ben_n_nx = ben_n_q;
    commit   = 1'b0;
    rd_enter = 1'b0;
    wr_latch = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req) begin
          state_nx = WRITE;
          wr_latch = 1'b1;
        end else if (rd_req) begin
          addr_nx = SRAM_ADDR;
          lat_nx  = LAT_LOAD;
          if (READ_LAT == 1) begin
            state_nx = READ_DRIVE;
            rd_enter = 1'b1;
          end else begin
            state_nx = READ_WAIT;
          end
        end
      end
      READ_WAIT: begin
        if (wr_req) begin
          state_nx = WRITE;
          wr_latch = 1'b1;
        end else if (!rd_req) begin
          state_nx = IDLE;
        end else if (addr_chg) begin
          addr_nx = SRAM_ADDR;
          lat_nx  = LAT_LOAD;
        end else if (lat_cnt <= 3'd1) begin
          lat_nx   = 3'd0;
          state_nx = READ_DRIVE;
          rd_enter = 1'b1;
        end else begin
          lat_nx = lat_cnt - 3'd1;
        end
      end
      READ_DRIVE: begin
        if (wr_req) begin
          state_nx = WRITE;
          wr_latch = 1'b1;
        end else if (!rd_req) begin
          state_nx = IDLE;
        end else if (addr_chg) begin
          addr_nx  = SRAM_ADDR;
          lat_nx   = LAT_LOAD;
          state_nx = READ_WAIT;
        end
      end
      WRITE: begin
        if (SRAM_WE_N || SRAM_CE_N) begin
          commit   = 1'b1;
          state_nx = IDLE;
        end else begin
          wr_latch = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (wr_latch) begin
      addr_nx  = SRAM_ADDR;
      wdata_nx = SRAM_DQ;
      ben_n_nx = {SRAM_UB_N, SRAM_LB_N};
    end
  end

  // Lane 0 is the low byte (LB_N), lane 1 the high byte (UB_N).
  logic [NUM_LANES-1:0]      rd_en_n, lane_we;
  logic [NUM_LANES-1:0][7:0] lane_rd, lane_dbg;

  assign rd_en_n = {SRAM_UB_N, SRAM_LB_N};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_we[i] = commit & rst & ~ben_n_q[i];
    sram_byte_lane #(.AW(MEM_AW)) u_lane (
      .clk      (clk),
      .we       (lane_we[i]),
      .waddr    (addr_q[MEM_AW-1:0]),
      .wdata    (wdata_q[8*i +: 8]),
      .raddr    (addr_nx[MEM_AW-1:0]),
      .rdata    (lane_rd[i]),
      .dbg_addr (dbg_addr),
      .dbg_data (lane_dbg[i])
    );
    assign rd_masked[8*i +: 8] = rd_en_n[i] ? 8'h00 : lane_rd[i];
  end

  assign dbg_data = lane_dbg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ben_n_q  <= '1;
      dq_out   <= '0;
      dq_oe    <= 1'b0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      state   <= state_nx;
      lat_cnt <= lat_nx;
      addr_q  <= addr_nx;
      wdata_q <= wdata_nx;
      ben_n_q <= ben_n_nx;
      dq_oe   <= (state_nx == READ_DRIVE);
      dq_out  <= (state_nx == READ_DRIVE) ? rd_masked : 16'h0;
      if (rd_enter && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if (commit && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end

`ifdef SRAM_PROTOCOL_CHECK_EN
  logic perr_hit;

  always_comb begin
    perr_hit = (~SRAM_CE_N & ~SRAM_OE_N & ~SRAM_WE_N) ||
               (state == WRITE && ~SRAM_WE_N && addr_chg);
`ifndef SYNTHESIS
    if (wr_latch && $isunknown(SRAM_DQ)) perr_hit = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst)          proto_err <= 1'b0;
    else if (perr_hit) proto_err <= 1'b1;
  end
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: a transaction-level memory/bus model drives per-cycle checks.
module tb_sram_responder;
  localparam int AW  = 10;
  localparam int LAT = 2;

  logic              clk = 1'b0;
  logic              rst;
  tri1  [15:0]       dq;
  logic [15:0]       tb_dq;
  logic              tb_oe;
  logic [17:0]       addr;
  logic              ub_n, lb_n, we_n, ce_n, oe_n;
  logic [AW-1:0]     dbg_addr;
  logic [15:0]       dbg_data, rd_count, wr_count;
  logic              proto_err;

  assign dq = tb_oe ? tb_dq : 16'hzzzz;
  always #5 clk = ~clk;

  sram_responder #(.MEM_AW(AW), .READ_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .SRAM_DQ(dq), .SRAM_ADDR(addr),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .rd_count(rd_count), .wr_count(wr_count),
    .proto_err(proto_err)
  );

  // Model state
  logic [15:0] mem_m [0:(1<<AW)-1];
  bit          known [0:(1<<AW)-1];
  int          exp_rd, exp_wr;
  bit          exp_perr;
  bit          chk_on, chk_dq, exp_z;
  logic [15:0] exp_dq, last_dq;
  int          n_chk, n_err;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] bmask(input logic [15:0] d, input logic ub, input logic lb);
    return {ub ? 8'h00 : d[15:8], lb ? 8'h00 : d[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One compare process: checks every cycle once the bench has taken the DUT out of reset.
  always @(negedge clk) begin
    if (chk_on) begin
      if (chk_dq) begin
        cmp("dq", dq, exp_z ? 16'hFFFF : exp_dq);
        if (!exp_z) last_dq = dq;
      end
      cmp("rd_count", rd_count, 16'(exp_rd));
      cmp("wr_count", wr_count, 16'(exp_wr));
      cmp("proto_err", {15'b0, proto_err}, {15'b0, exp_perr});
      if (known[dbg_addr]) cmp("dbg_data", dbg_data, mem_m[dbg_addr]);
    end
  end

  task automatic chk_mem(input string name, input logic [AW-1:0] a, input logic [15:0] lit);
    dbg_addr = a;
    #1;
    cmp(name, dbg_data, lit);
  endtask

  // Write: WE_N/CE_N low for n cycles (d_early then d on the last), then both high to commit.
  task automatic do_write(input logic [17:0] a, input logic [15:0] d, input logic ub,
                          input logic lb, input int n, input logic [15:0] d_early);
    int idx;
    chk_dq = 0;
    addr = a; ub_n = ub; lb_n = lb; we_n = 0; ce_n = 0; oe_n = 1; tb_oe = 1;
    for (int k = 0; k < n; k++) begin
      tb_dq = (k == n - 1) ? d : d_early;
      tick();
    end
    we_n = 1; ce_n = 1;
    tick();
    tb_oe = 0;
    idx = int'(a[AW-1:0]);
    if (!lb) mem_m[idx][7:0]  = d[7:0];
    if (!ub) mem_m[idx][15:8] = d[15:8];
    if (!ub && !lb) known[idx] = 1;
    exp_wr++;
    chk_dq = 1; exp_z = 1;
  endtask

  // Read held for n cycles; the address switches from a0 to a1 in cycle sw.
  // Data appears once the address seen one cycle earlier has been stable for LAT cycles.
  task automatic do_read(input logic [17:0] a0, input logic [17:0] a1, input int sw,
                         input int n, input logic ub, input logic lb);
    logic [17:0] pa;
    int          pc;
    bit          preq;
    for (int k = 0; k <= n + 1; k++) begin
      if (k < n) begin
        ce_n = 0; oe_n = 0; we_n = 1; ub_n = ub; lb_n = lb;
        addr = (k >= sw) ? a1 : a0;
      end else begin
        ce_n = 1; oe_n = 1;
      end
      preq = (k >= 1) && (k - 1 < n);
      pa   = (k - 1 >= sw) ? a1 : a0;
      pc   = (k - 1 >= sw) ? sw : 0;
      chk_dq = 1;
      if (preq && k >= pc + LAT) begin
        exp_z  = 0;
        exp_dq = bmask(mem_m[int'(pa[AW-1:0])], ub, lb);
        if (k == pc + LAT) exp_rd++;
      end else begin
        exp_z = 1;
      end
      tick();
    end
    exp_z = 1;
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    chk_on = 0; chk_dq = 0; exp_z = 1; exp_dq = '0; last_dq = '0;
    exp_rd = 0; exp_wr = 0; exp_perr = 0;
    rst = 0; tb_oe = 0; tb_dq = '0; addr = '0;
    ub_n = 1; lb_n = 1; we_n = 1; ce_n = 1; oe_n = 1; dbg_addr = 5;
    tick(); tick();
    rst = 1; chk_on = 1; chk_dq = 1;
    cmp("reset_rd_count", rd_count, 16'h0000);
    cmp("reset_wr_count", wr_count, 16'h0000);
    cmp("reset_dq_z", dq, 16'hFFFF);
    tick();

    do_write(18'd5, 16'hBEEF, 0, 0, 2, 16'hBEEF);
    chk_mem("lit_beef", 5, 16'hBEEF);
    cmp("lit_wr_count_1", wr_count, 16'd1);

    do_read(18'd5, 18'd5, 99, 4, 0, 0);
    cmp("lit_rd_beef", last_dq, 16'hBEEF);
    cmp("lit_rd_count_1", rd_count, 16'd1);

    do_write(18'd5, 16'h1234, 1, 0, 1, 16'h1234);
    chk_mem("lit_be34", 5, 16'hBE34);
    do_read(18'd5, 18'd5, 99, 3, 0, 1);
    cmp("lit_upper_read", last_dq, 16'hBE00);

    do_write(18'd6, 16'hA5C3, 0, 0, 3, 16'h1111);
    chk_mem("lit_last_wins", 6, 16'hA5C3);
    do_read(18'd5, 18'd6, 1, 5, 0, 0);
    cmp("lit_switch_wait", last_dq, 16'hA5C3);
    do_read(18'd5, 18'd6, 3, 7, 0, 0);
    do_read(18'd6, 18'd6, 99, 1, 0, 0);
    cmp("lit_abort_count", rd_count, 16'd5);

    do_write(18'h00405, 16'hC0DE, 0, 0, 1, 16'hC0DE);
    chk_mem("lit_alias", 5, 16'hC0DE);
    do_read(18'h20005, 18'h20005, 99, 3, 1, 0);
    cmp("lit_alias_read", last_dq, 16'h00DE);

    do_write(18'd7, 16'h0F0F, 0, 0, 1, 16'h0F0F);
    dbg_addr = 7;
    // Reset while a read is driving the bus.
    ce_n = 0; oe_n = 0; we_n = 1; addr = 18'd7; ub_n = 0; lb_n = 0;
    exp_z = 1; tick(); tick();
    exp_z = 0; exp_dq = 16'h0F0F; exp_rd++; tick();
    rst = 0; tick();
    rst = 1; ce_n = 1; oe_n = 1; exp_z = 1; exp_rd = 0; exp_wr = 0; tick();
    cmp("lit_rst_rd_count", rd_count, 16'd0);

    // Reset while a write of 16'h5555 to addr 7 is pending.
    chk_dq = 0; addr = 18'd7; tb_dq = 16'h5555; tb_oe = 1; we_n = 0; ce_n = 0; oe_n = 1;
    tick(); tick();
    rst = 0; tick();
    rst = 1; we_n = 1; ce_n = 1; tb_oe = 0; chk_dq = 1; exp_z = 1; tick();
    chk_mem("lit_rst_no_commit", 7, 16'h0F0F);
    cmp("lit_rst_wr_count", wr_count, 16'd0);
    cmp("lit_rst_dq_z", dq, 16'hFFFF);

    // OE_N, WE_N and CE_N all low together: a write plus, when checking is built, a protocol error.
    chk_dq = 0; addr = 18'd9; tb_dq = 16'h0909; tb_oe = 1; we_n = 0; ce_n = 0; oe_n = 0;
    tick();
`ifdef SRAM_PROTOCOL_CHECK_EN
    exp_perr = 1;
`endif
    we_n = 1; ce_n = 1; oe_n = 1; tick();
    tb_oe = 0; mem_m[9] = 16'h0909; known[9] = 1; exp_wr++; chk_dq = 1; exp_z = 1;
    tick(); tick();
`ifdef SRAM_PROTOCOL_CHECK_EN
    cmp("lit_proto_set", {15'b0, proto_err}, 16'd1);
`else
    cmp("lit_proto_off", {15'b0, proto_err}, 16'd0);
`endif
    chk_mem("lit_0909", 9, 16'h0909);
    rst = 0; tick();
    rst = 1; exp_perr = 0; exp_rd = 0; exp_wr = 0; tick();
    cmp("lit_proto_cleared", {15'b0, proto_err}, 16'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Clocked, bench-usable model of the 16-bit asynchronous SRAM chip on the far side of the SRAM_* pin bus.
- Responds to the pin-level access sequences produced by the MEM-stage SRAM controller.
  - Read: drives SRAM_DQ after a programmable latency.
  - Write: commits byte-masked data into an internal array.
- Exposes a backdoor port and access counters so benches can check memory contents without going through the controller.

Parameters:
- MEM_AW, 10, number of low SRAM_ADDR bits decoded. Array depth is 2^MEM_AW words. Upper address bits are ignored, so addresses alias.
- READ_LAT, 2, clock cycles from a read being recognised to SRAM_DQ being driven. Legal range 1..7.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset
- SRAM_DQ  inout  16  data bus. Driven by this block only in READ_DRIVE, high-Z otherwise.
- SRAM_ADDR  input  18  word address
- SRAM_UB_N  input  1  upper byte enable, active-low
- SRAM_LB_N  input  1  lower byte enable, active-low
- SRAM_WE_N  input  1  write enable, active-low
- SRAM_CE_N  input  1  chip enable, active-low
- SRAM_OE_N  input  1  output enable, active-low
- dbg_addr  input  MEM_AW  backdoor read address
- dbg_data  output  16  combinational array word at dbg_addr
- rd_count  output  16  completed reads, saturating at 16'hFFFF
- wr_count  output  16  committed writes, saturating at 16'hFFFF
- proto_err  output  1  sticky protocol-violation flag (see Optional Feature)

Behaviour:
- Reset (rst=0 at a rising clk edge):
  - State goes to IDLE; DQ output enable=0; dq_out=0.
  - rd_count=0, wr_count=0, proto_err=0.
  - Array contents are NOT cleared.
- Decode, evaluated each cycle on the pin values sampled at the edge:
  - sel = ~CE_N
  - wr_req = sel & ~WE_N
  - rd_req = sel & WE_N & ~OE_N
  - wr_req has priority over rd_req.
- FSM states: IDLE, READ_WAIT, READ_DRIVE, WRITE.
- IDLE:
  - wr_req: go to WRITE; latch addr, DQ, UB_N, LB_N.
  - else rd_req: latch addr, load lat_cnt=READ_LAT-1. Go to READ_WAIT, or straight to READ_DRIVE if READ_LAT=1.
- READ_WAIT:
  - lat_cnt decrements each cycle; go to READ_DRIVE when it reaches 0.
  - rd_req drops: return to IDLE, rd_count unchanged.
  - Address differs from latched addr: reload lat_cnt and relatch the address (latency restarts).
  - wr_req: abort the read and go to WRITE.
- READ_DRIVE:
  - Drive SRAM_DQ with array[addr]. Disabled bytes are driven 8'h00.
  - rd_count increments once on entry.
  - Address change: return to READ_WAIT with latency reload; the bus goes high-Z the next cycle.
  - rd_req drops or wr_req: release the bus the same edge and leave for IDLE/WRITE.
- WRITE:
  - Each cycle WE_N stays low, relatch DQ, addr and byte enables; the last sampled values win.
  - Commit on the first edge where WE_N=1 or CE_N=1, then go to IDLE.
  - Commit writes array[addr[MEM_AW-1:0]] bytes whose enable is low and increments wr_count.
  - Both byte enables high: no array change, wr_count still increments.
- Bus discipline:
  - SRAM_DQ is never driven while WE_N=0.
  - The bus is released within one cycle of OE_N or CE_N deasserting.
- Reset mid-operation:
  - A pending write is discarded, not committed.
  - The bus is released immediately at the reset edge.

Optional Feature:
- Macro: SRAM_PROTOCOL_CHECK_EN.
- When defined, proto_err sets (sticky until reset) on any of:
  - SRAM_ADDR changing while in WRITE with WE_N low;
  - OE_N=0 and WE_N=0 simultaneously with CE_N=0;
  - SRAM_DQ containing X/Z on a WRITE sampling edge (simulation only).
- When undefined, proto_err is tied to 0 and no checking logic is built.

Test Plan:
- Write 16'hBEEF to addr 5 (UB_N=LB_N=0, WE_N low 2 cycles), then raise WE_N -> dbg_addr=5 reads 16'hBEEF; wr_count=1.
- Read addr 5 with READ_LAT=2, OE_N/CE_N low from cycle 0 -> SRAM_DQ high-Z in cycles 0-1, 16'hBEEF from cycle 2; rd_count=1.
- Byte write 16'h1234 to addr 5 with LB_N=0, UB_N=1 -> dbg_data=16'hBE34. Upper-only read (LB_N=1) -> DQ=16'hBE00.
- Address switches 5->6 during READ_WAIT -> latency restarts; DQ shows array[6] exactly READ_LAT cycles after the switch.
- rst=0 while WRITE holds 16'h5555 to addr 7 -> array[7] unchanged, counters 0, DQ high-Z.
- With SRAM_PROTOCOL_CHECK_EN, drive OE_N=WE_N=CE_N=0 -> proto_err=1, held until rst=0. Without the macro -> proto_err stays 0.
